// File: rtl/cxl_get_quota.sv
// Per-client usage quota checker: a 3-state request/decision/response FSM over a
// usage table that is wiped every WINDOW cycles.
module cxl_get_quota #(
    parameter int               N_CLIENTS = 32,
    parameter int               ID_W      = 5,
    parameter int               AMT_W     = 32,
    parameter logic [AMT_W-1:0] QUOTA     = 'h1000,
    parameter int               WINDOW    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  client_id,
    input  logic [AMT_W-1:0] amount,
    output logic             resp_valid,
    output logic             ack,
    output logic             nack,
    output logic [ID_W-1:0]  resp_id,
    output logic [AMT_W-1:0] resp_used
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [ID_W:0] N_LIM = (ID_W + 1)'(N_CLIENTS);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [AMT_W-1:0] usage_q [N_CLIENTS];
    logic [AMT_W-1:0] usage_d [N_CLIENTS];
    logic [WIN_W-1:0] win_q, win_d;
    logic             resp_valid_q, resp_valid_d;
    logic             ack_q, ack_d;
    logic             nack_q, nack_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [AMT_W-1:0] resp_used_q, resp_used_d;

    logic             id_ok, grant, wrap;
    logic [IDX_W-1:0] idx;
    logic [AMT_W-1:0] cur_use;
    logic [AMT_W:0]   sum;

    // The extra sum bit catches a carry, so a huge amount can never wrap into a grant.
    assign id_ok   = {1'b0, id_q} < N_LIM;
    assign idx     = id_q[IDX_W-1:0];
    assign cur_use = id_ok ? usage_q[idx] : '0;
    assign sum     = {1'b0, cur_use} + {1'b0, amt_q};
    assign grant   = id_ok && (sum <= {1'b0, QUOTA});
    assign wrap    = (win_q == WIN_W'(WINDOW - 1));

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        amt_d        = amt_q;
        usage_d      = usage_q;
        win_d        = wrap ? '0 : win_q + 1'b1;
        resp_valid_d = 1'b0;
        ack_d        = 1'b0;
        nack_d       = 1'b0;
        resp_id_d    = resp_id_q;
        resp_used_d  = resp_used_q;

        if (wrap) begin
            for (int i = 0; i < N_CLIENTS; i++) usage_d[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    id_d    = client_id;
                    amt_d   = amount;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                // Decision always uses pre-clear usage; a grant on the wrap edge keeps only this amount.
                if (grant) begin
                    ack_d          = 1'b1;
                    usage_d[idx]   = wrap ? amt_q : sum[AMT_W-1:0];
                    resp_used_d    = wrap ? amt_q : sum[AMT_W-1:0];
                end else begin
                    nack_d      = 1'b1;
                    resp_used_d = (id_ok && !wrap) ? cur_use : '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            amt_q        <= '0;
            win_q        <= '0;
            resp_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            nack_q       <= 1'b0;
            resp_id_q    <= '0;
            resp_used_q  <= '0;
            for (int i = 0; i < N_CLIENTS; i++) usage_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            amt_q        <= amt_d;
            win_q        <= win_d;
            resp_valid_q <= resp_valid_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            resp_id_q    <= resp_id_d;
            resp_used_q  <= resp_used_d;
            usage_q      <= usage_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign ack        = ack_q;
    assign nack       = nack_q;
    assign resp_id    = resp_id_q;
    assign resp_used  = resp_used_q;

endmodule

// File: tb/tb_cxl_get_quota.sv
// Directed bench: three instances (defaults, 8 clients, 16-cycle window) sharing clk/rst.
module tb_cxl_get_quota;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic [4:0]  client_id;
    logic [31:0] amount;
    logic [1:0]  sel;

    logic [2:0]  rdy, rv, ak, nk;
    logic [4:0]  rid   [3];
    logic [31:0] rused [3];

    int errs = 0;
    int checks = 0;
    int win_m = 0;

    logic        r_early;
    logic [39:0] obs, exp_v;

    cxl_get_quota u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd0), .req_ready(rdy[0]),
        .client_id(client_id), .amount(amount), .resp_valid(rv[0]), .ack(ak[0]),
        .nack(nk[0]), .resp_id(rid[0]), .resp_used(rused[0])
    );

    cxl_get_quota #(.N_CLIENTS(8)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd1), .req_ready(rdy[1]),
        .client_id(client_id), .amount(amount), .resp_valid(rv[1]), .ack(ak[1]),
        .nack(nk[1]), .resp_id(rid[1]), .resp_used(rused[1])
    );

    cxl_get_quota #(.WINDOW(16)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd2), .req_ready(rdy[2]),
        .client_id(client_id), .amount(amount), .resp_valid(rv[2]), .ack(ak[2]),
        .nack(nk[2]), .resp_id(rid[2]), .resp_used(rused[2])
    );

    // Expected phase of the 16-cycle window in u_c.
    always @(posedge clk) begin
        if (rst) win_m <= 0;
        else     win_m <= (win_m == 15) ? 0 : win_m + 1;
    end

    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
    task automatic txn(input logic [4:0] id, input logic [31:0] amt);
        client_id = id; amount = amt; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        r_early = rv[sel];
        @(negedge clk);
        obs = {rv[sel], ak[sel], nk[sel], rid[sel], rused[sel]};
        @(negedge clk);
    endtask

    task automatic wait_win(input int v);
        int n = 0;
        while (win_m != v && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (win_m != v) begin
            checks++; errs++;
            $display("FAIL wait_win phase got %0d exp %0d", win_m, v);
        end
    endtask

    task automatic test_reset;
        sel = 2'd0; rst = 1'b1; req_valid = 1'b0; client_id = '0; amount = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({rdy[s], rv[s], ak[s], nk[s], rid[s], rused[s]} !== {4'b1000, 5'h00, 32'h0}) begin
                errs++;
                $display("FAIL reset_state dut%0d got %h exp %h", s,
                         {rdy[s], rv[s], ak[s], nk[s], rid[s], rused[s]}, {4'b1000, 5'h00, 32'h0});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin
            errs++; $display("FAIL ready_after_reset got %b exp 1", rdy[0]);
        end
    endtask

    task automatic test_basic;
        sel = 2'd0;
        txn(5'h1B, 32'hC5);
        checks++;
        if (r_early !== 1'b0) begin
            errs++; $display("FAIL early_resp got %b exp 0", r_early);
        end
        exp_v = {3'b110, 5'h1B, 32'h0000_00C5}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL basic_first got %h exp %h", obs, exp_v); end
        txn(5'h1B, 32'hC5);
        exp_v = {3'b110, 5'h1B, 32'h0000_018A}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL basic_accum got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_quota;
        sel = 2'd0;
        txn(5'h08, 32'h1000);
        exp_v = {3'b110, 5'h08, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL quota_full got %h exp %h", obs, exp_v); end
        txn(5'h08, 32'h1);
        exp_v = {3'b101, 5'h08, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL quota_over got %h exp %h", obs, exp_v); end
        txn(5'h08, 32'h0);
        exp_v = {3'b110, 5'h08, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL quota_zero got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_overflow;
        sel = 2'd0;
        txn(5'h09, 32'h20C5);
        exp_v = {3'b101, 5'h09, 32'h0}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL big_amount got %h exp %h", obs, exp_v); end
        txn(5'h0A, 32'hC5);
        exp_v = {3'b110, 5'h0A, 32'h0000_00C5}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL carry_setup got %h exp %h", obs, exp_v); end
        txn(5'h0A, 32'hFFFF_FFFF);
        exp_v = {3'b101, 5'h0A, 32'h0000_00C5}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL carry_nack got %h exp %h", obs, exp_v); end
        txn(5'h0A, 32'h0F3B);
        exp_v = {3'b110, 5'h0A, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL exact_quota got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_rst_abort;
        sel = 2'd0;
        client_id = 5'h1B; amount = 32'h5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rdy[0], rv[0], ak[0], nk[0], rid[0], rused[0]} !== {4'b1000, 5'h00, 32'h0}) begin
            errs++;
            $display("FAIL abort_reset got %h exp %h",
                     {rdy[0], rv[0], ak[0], nk[0], rid[0], rused[0]}, {4'b1000, 5'h00, 32'h0});
        end
        @(negedge clk);
        checks++;
        if ({rdy[0], rv[0]} !== 2'b10) begin
            errs++; $display("FAIL abort_no_resp got %b exp 10", {rdy[0], rv[0]});
        end
        txn(5'h1B, 32'h5);
        exp_v = {3'b110, 5'h1B, 32'h0000_0005}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL abort_cleared got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_bad_client;
        sel = 2'd1;
        txn(5'h08, 32'h1);
        exp_v = {3'b101, 5'h08, 32'h0}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL bad_client got %h exp %h", obs, exp_v); end
        txn(5'h07, 32'h1);
        exp_v = {3'b110, 5'h07, 32'h0000_0001}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL last_client got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] mask, exp_mask;
        sel = 2'd1;
        client_id = 5'h07; amount = 32'h1; req_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            mask[k-1]     = rv[1];
            exp_mask[k-1] = (k % 3 == 2);
        end
        req_valid = 1'b0;
        checks++;
        if (mask !== exp_mask) begin
            errs++; $display("FAIL b2b_pattern got %b exp %b", mask, exp_mask);
        end
        checks++;
        if (rused[1] !== 32'h5) begin
            errs++; $display("FAIL b2b_usage got %h exp %h", rused[1], 32'h5);
        end
    endtask

    task automatic test_window;
        sel = 2'd2;
        wait_win(0);
        txn(5'h06, 32'h1000);
        exp_v = {3'b110, 5'h06, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL win_fill got %h exp %h", obs, exp_v); end
        txn(5'h06, 32'h1);
        exp_v = {3'b101, 5'h06, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL win_full got %h exp %h", obs, exp_v); end
        wait_win(0);
        txn(5'h06, 32'h1000);
        exp_v = {3'b110, 5'h06, 32'h0000_1000}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL win_refill got %h exp %h", obs, exp_v); end

        // Decision on the wrap edge must see pre-clear usage FF0 -> refuse.
        wait_win(0);
        txn(5'h03, 32'h0FF0);
        exp_v = {3'b110, 5'h03, 32'h0000_0FF0}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_setup_a got %h exp %h", obs, exp_v); end
        wait_win(14);
        txn(5'h03, 32'h20);
        checks++;
        if (obs[39:32] !== {3'b101, 5'h03}) begin
            errs++; $display("FAIL wrap_preclear got %h exp %h", obs[39:32], {3'b101, 5'h03});
        end
        txn(5'h03, 32'h0);
        exp_v = {3'b110, 5'h03, 32'h0}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_nack_clear got %h exp %h", obs, exp_v); end

        // Grant landing on the wrap edge keeps only the amount; others clear.
        txn(5'h03, 32'h10);
        exp_v = {3'b110, 5'h03, 32'h0000_0010}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_setup_b got %h exp %h", obs, exp_v); end
        txn(5'h05, 32'h7);
        exp_v = {3'b110, 5'h05, 32'h0000_0007}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_setup_c got %h exp %h", obs, exp_v); end
        wait_win(14);
        txn(5'h03, 32'h20);
        exp_v = {3'b110, 5'h03, 32'h0000_0020}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_grant got %h exp %h", obs, exp_v); end
        txn(5'h05, 32'h0);
        exp_v = {3'b110, 5'h05, 32'h0}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_other got %h exp %h", obs, exp_v); end
        txn(5'h03, 32'h0);
        exp_v = {3'b110, 5'h03, 32'h0000_0020}; checks++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_kept got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quota();
        test_overflow();
        test_rst_abort();
        test_bad_client();
        test_back_to_back();
        test_window();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
